debug_step_controller: RTL and testbench

Host-facing debug sequencer that sits directly upstream of the instruction phase decoder. It converts host commands (run, halt, step N, set breakpoint) into the decoder's DEBUG_STOPX level and the DEBUG_STEP_REQ/DEBUG_STEP_ACK four-phase handshake. It also watches the PC at each FETCH phase for a single hardware breakpoint.

---
 rtl/debug_step_controller_pkg.sv | 28 ++
 rtl/debug_step_controller_if.sv | 38 +++
 rtl/debug_step_controller_bp.sv | 42 ++++
 rtl/debug_step_controller.sv | 147 ++++++++++++++
 tb/tb_debug_step_controller.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_step_controller_pkg.sv
// Shared command codes, state encodings and defaults for the debug step controller.
// Imported by the controller top and its breakpoint sub-module.
package debug_step_controller_pkg;

    localparam int DSC_ADDR_WIDTH  = 16;
    localparam int DSC_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        CMD_RUN    = 2'b00,
        CMD_HALT   = 2'b01,
        CMD_STEP   = 2'b10,
        CMD_SET_BP = 2'b11
    } dsc_cmd_e;

    typedef enum logic [2:0] {
        DSC_RUN      = 3'd0,
        DSC_HALTING  = 3'd1,
        DSC_HALTED   = 3'd2,
        DSC_STEP_REQ = 3'd3,
        DSC_STEP_REL = 3'd4
    } dsc_state_e;

    // Host commands are only taken while free-running or fully halted.
    function automatic logic dsc_accepts_cmd(input dsc_state_e s);
        return (s == DSC_RUN) || (s == DSC_HALTED);
    endfunction

endpackage

// File: rtl/debug_step_controller_if.sv
// Host command bus plus decoder debug handshake bundled for the step controller.
// The slave modport is the controller's view; master is the host/decoder side.
interface debug_step_controller_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
);

    logic                   CMD_VALID;
    logic [1:0]             CMD;
    logic [ADDR_WIDTH-1:0]  CMD_ARG;
    logic                   CMD_READY;
    logic                   STOPPED;
    logic                   DEBUG_ACTIVE;
    logic                   DEBUG_STEP_ACK;
    logic                   FETCH;
    logic [ADDR_WIDTH-1:0]  PC;
    logic                   DEBUG_STOPX;
    logic                   DEBUG_STEP_REQ;
    logic                   HALTED;
    logic                   BP_HIT;
    logic                   STEP_DONE;
    logic [COUNT_WIDTH-1:0] STEPS_LEFT;

    modport master (
        output CMD_VALID, CMD, CMD_ARG,
        output STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK, FETCH, PC,
        input  CMD_READY, DEBUG_STOPX, DEBUG_STEP_REQ, HALTED,
        input  BP_HIT, STEP_DONE, STEPS_LEFT
    );

    modport slave (
        input  CMD_VALID, CMD, CMD_ARG,
        input  STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK, FETCH, PC,
        output CMD_READY, DEBUG_STOPX, DEBUG_STEP_REQ, HALTED,
        output BP_HIT, STEP_DONE, STEPS_LEFT
    );

endinterface

// File: rtl/debug_step_controller_bp.sv
// Single hardware breakpoint: holds the address/enable registers and flags a
// FETCH of the matching PC in the same cycle.
module debug_breakpoint_match
    import debug_step_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = DSC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  fetch,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  hit
);

    logic [ADDR_WIDTH-1:0] bp_addr_q, bp_addr_d;
    logic                  bp_en_q, bp_en_d;

    // An all-ones address is the host's way of disarming the breakpoint.
    always_comb begin
        bp_addr_d = bp_addr_q;
        bp_en_d   = bp_en_q;
        if (load) begin
            bp_addr_d = load_addr;
            bp_en_d   = (load_addr != '1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_addr_q <= '1;
            bp_en_q   <= 1'b0;
        end else begin
            bp_addr_q <= bp_addr_d;
            bp_en_q   <= bp_en_d;
        end
    end

    assign hit = fetch && bp_en_q && (pc == bp_addr_q);

endmodule

// File: rtl/debug_step_controller.sv
// Host-facing debug sequencer: turns run/halt/step/breakpoint commands into the
// decoder's DEBUG_STOPX level and the four-phase step request/acknowledge.
module debug_step_controller
    import debug_step_controller_pkg::*;
#(
    parameter int ADDR_WIDTH  = DSC_ADDR_WIDTH,
    parameter int COUNT_WIDTH = DSC_COUNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    debug_step_controller_if.slave bus
);

    dsc_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] steps_left_q, steps_left_d;
    logic [COUNT_WIDTH-1:0] steps_dec;
    logic [COUNT_WIDTH-1:0] step_count;
    logic                   bp_hit_q, bp_hit_d;
    logic                   step_done_q, step_done_d;
    logic                   stopx_q, stopx_d;
    logic                   step_req_q, step_req_d;
    logic                   halted_q, halted_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   cmd_accept;
    logic                   bp_load;
    logic                   bp_match;
    dsc_cmd_e               cmd;

    assign cmd        = dsc_cmd_e'(bus.CMD);
    assign cmd_accept = bus.CMD_VALID && cmd_ready_q;
    assign step_count = bus.CMD_ARG[COUNT_WIDTH-1:0];
    assign steps_dec  = (steps_left_q != '0) ? steps_left_q - COUNT_WIDTH'(1) : '0;

    debug_breakpoint_match #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bp (
        .clk       (CLK),
        .reset     (RESET),
        .load      (bp_load),
        .load_addr (bus.CMD_ARG),
        .fetch     (bus.FETCH),
        .pc        (bus.PC),
        .hit       (bp_match)
    );

    // Next-state logic; a breakpoint and a HALT in the same cycle collapse into one transition.
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        bp_hit_d     = bp_hit_q;
        step_done_d  = 1'b0;
        bp_load      = 1'b0;

        unique case (state_q)
            DSC_RUN: begin
                if (cmd_accept && cmd == CMD_SET_BP) begin
                    bp_load = 1'b1;
                end
                if (bp_match) begin
                    bp_hit_d = 1'b1;
                    state_d  = DSC_HALTING;
                end else if (cmd_accept && cmd == CMD_HALT) begin
                    state_d = DSC_HALTING;
                end
            end
            DSC_HALTING: begin
                if (bus.DEBUG_ACTIVE && bus.STOPPED && !bus.DEBUG_STEP_ACK) begin
                    state_d = DSC_HALTED;
                end
            end
            DSC_HALTED: begin
                if (cmd_accept) begin
                    unique case (cmd)
                        CMD_RUN: begin
                            bp_hit_d = 1'b0;
                            state_d  = DSC_RUN;
                        end
                        CMD_STEP: begin
                            if (step_count == '0) begin
                                step_done_d = 1'b1;
                            end else begin
                                bp_hit_d     = 1'b0;
                                steps_left_d = step_count;
                                state_d      = DSC_STEP_REQ;
                            end
                        end
                        CMD_SET_BP: bp_load = 1'b1;
                        CMD_HALT:   ;
                    endcase
                end
            end
            DSC_STEP_REQ: begin
                if (bus.DEBUG_STEP_ACK) begin
                    state_d = DSC_STEP_REL;
                end
            end
            DSC_STEP_REL: begin
                if (!bus.DEBUG_STEP_ACK) begin
                    steps_left_d = steps_dec;
                    if (steps_dec == '0) begin
                        step_done_d = 1'b1;
                        state_d     = DSC_HALTED;
                    end else begin
                        state_d = DSC_STEP_REQ;
                    end
                end
            end
            default: state_d = DSC_RUN;
        endcase

        stopx_d     = (state_d != DSC_RUN);
        step_req_d  = (state_d == DSC_STEP_REQ);
        halted_d    = (state_d == DSC_HALTED);
        cmd_ready_d = dsc_accepts_cmd(state_d);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= DSC_RUN;
            steps_left_q <= '0;
            bp_hit_q     <= 1'b0;
            step_done_q  <= 1'b0;
            stopx_q      <= 1'b0;
            step_req_q   <= 1'b0;
            halted_q     <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            bp_hit_q     <= bp_hit_d;
            step_done_q  <= step_done_d;
            stopx_q      <= stopx_d;
            step_req_q   <= step_req_d;
            halted_q     <= halted_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign bus.CMD_READY      = cmd_ready_q;
    assign bus.DEBUG_STOPX    = stopx_q;
    assign bus.DEBUG_STEP_REQ = step_req_q;
    assign bus.HALTED         = halted_q;
    assign bus.BP_HIT         = bp_hit_q;
    assign bus.STEP_DONE      = step_done_q;
    assign bus.STEPS_LEFT     = steps_left_q;

endmodule

// File: tb/tb_debug_step_controller.sv
// Self-checking bench for debug_step_controller: directed vector table, handshake
// sequences against a small decoder model, and random traffic against a reference model.
module tb_debug_step_controller;
    import debug_step_controller_pkg::*;

    localparam int AW = 16;
    localparam int CW = 8;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    debug_step_controller_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    debug_step_controller #(
        .ADDR_WIDTH  (AW),
        .COUNT_WIDTH (CW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    // Reference model: "stopped" is the STOPX level, "halted" the parked condition,
    // "req"/"rel" the two halves of a step handshake.
    logic          m_stopx, m_halted, m_req, m_rel, m_bp_hit, m_done, m_bp_en;
    logic [CW-1:0] m_steps;
    logic [AW-1:0] m_bp_addr;

    typedef struct {
        logic          rst;
        logic          valid;
        logic [1:0]    cmd;
        logic [AW-1:0] arg;
        logic          fetch;
        logic [AW-1:0] pc;
        logic          active;
        logic          stopped;
        logic          ack;
        logic [13:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic model_ready();
        return !m_stopx || m_halted;
    endfunction

    function automatic logic [13:0] model_vec();
        return {model_ready(), m_stopx, m_req, m_halted, m_bp_hit, m_done, m_steps};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.CMD_READY, bus.DEBUG_STOPX, bus.DEBUG_STEP_REQ, bus.HALTED,
                bus.BP_HIT, bus.STEP_DONE, bus.STEPS_LEFT};
    endfunction

    function automatic logic [13:0] mk_exp(input logic ready, stopx, req, halted, bp, done,
                                           input logic [CW-1:0] steps);
        return {ready, stopx, req, halted, bp, done, steps};
    endfunction

    task automatic model_update();
        logic          accept;
        logic          hit;
        logic [CW-1:0] n;
        accept = bus.CMD_VALID && model_ready();
        hit    = bus.FETCH && m_bp_en && (bus.PC == m_bp_addr);
        n      = bus.CMD_ARG[CW-1:0];
        m_done = 1'b0;
        if (RESET) begin
            m_stopx = 0; m_halted = 0; m_req = 0; m_rel = 0; m_bp_hit = 0;
            m_steps = '0; m_bp_addr = '1; m_bp_en = 0;
        end else if (!m_stopx) begin
            if (accept && bus.CMD == CMD_SET_BP) begin
                m_bp_addr = bus.CMD_ARG;
                m_bp_en   = (bus.CMD_ARG != '1);
            end
            if (hit) m_bp_hit = 1;
            if (hit || (accept && bus.CMD == CMD_HALT)) m_stopx = 1;
        end else if (m_halted) begin
            if (accept) begin
                if (bus.CMD == CMD_RUN) begin
                    m_stopx = 0; m_halted = 0; m_bp_hit = 0;
                end else if (bus.CMD == CMD_STEP) begin
                    if (n == 0) m_done = 1;
                    else begin
                        m_bp_hit = 0; m_steps = n; m_halted = 0; m_req = 1;
                    end
                end else if (bus.CMD == CMD_SET_BP) begin
                    m_bp_addr = bus.CMD_ARG;
                    m_bp_en   = (bus.CMD_ARG != '1);
                end
            end
        end else if (m_req) begin
            if (bus.DEBUG_STEP_ACK) begin
                m_req = 0; m_rel = 1;
            end
        end else if (m_rel) begin
            if (!bus.DEBUG_STEP_ACK) begin
                m_rel = 0;
                if (m_steps != 0) m_steps = m_steps - 1;
                if (m_steps == 0) begin
                    m_done = 1; m_halted = 1;
                end else m_req = 1;
            end
        end else begin
            if (bus.DEBUG_ACTIVE && bus.STOPPED && !bus.DEBUG_STEP_ACK) m_halted = 1;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge CLK);
        #1;
        check_output("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic apply_stimulus(input logic rst, input logic valid, input logic [1:0] cmd,
                                  input logic [AW-1:0] arg, input logic fetch,
                                  input logic [AW-1:0] pc, input logic active,
                                  input logic stopped, input logic ack);
        RESET              = rst;
        bus.CMD_VALID      = valid;
        bus.CMD            = cmd;
        bus.CMD_ARG        = arg;
        bus.FETCH          = fetch;
        bus.PC             = pc;
        bus.DEBUG_ACTIVE   = active;
        bus.STOPPED        = stopped;
        bus.DEBUG_STEP_ACK = ack;
    endtask

    task automatic add(input logic rst, valid, input logic [1:0] cmd, input logic [AW-1:0] arg,
                       input logic fetch, input logic [AW-1:0] pc, input logic active, stopped, ack,
                       input logic [13:0] exp);
        vec_t v;
        v.rst = rst; v.valid = valid; v.cmd = cmd; v.arg = arg; v.fetch = fetch; v.pc = pc;
        v.active = active; v.stopped = stopped; v.ack = ack; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic          ack;
        logic          prev_req;
        logic          done_seen;
        int            req_cnt, rel_cnt, rises, dones;
        logic [CW-1:0] trace[$];
        logic [1:0]    rc;

        apply_stimulus(1, 0, CMD_RUN, '0, 0, '0, 0, 0, 0);

        add(1,0,CMD_RUN,   16'h0000,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(1,0,CMD_RUN,   16'h0000,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,1,CMD_SET_BP,16'h0040,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,1,16'h003E,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,1,16'h003F,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,1,16'h0040,0,0,0, mk_exp(0,1,0,0,1,0,0));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(1,1,0,1,1,0,0));
        add(0,1,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(1,0,0,0,0,0,0));
        add(0,1,CMD_HALT,  16'h0000,0,16'h0000,0,0,0, mk_exp(0,1,0,0,0,0,0));
        add(0,1,CMD_HALT,  16'h0000,0,16'h0000,0,0,0, mk_exp(0,1,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,1, mk_exp(0,1,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(1,1,0,1,0,0,0));
        add(0,1,CMD_STEP,  16'h0000,0,16'h0000,1,1,0, mk_exp(1,1,0,1,0,1,0));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(1,1,0,1,0,0,0));
        add(0,1,CMD_STEP,  16'h0002,0,16'h0000,1,1,0, mk_exp(0,1,1,0,0,0,2));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,1, mk_exp(0,1,0,0,0,0,2));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,1, mk_exp(0,1,0,0,0,0,2));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(0,1,1,0,0,0,1));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,1, mk_exp(0,1,0,0,0,0,1));
        add(0,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(1,1,0,1,0,1,0));
        add(0,1,CMD_STEP,  16'h0301,0,16'h0000,1,1,0, mk_exp(0,1,1,0,0,0,1));
        add(1,0,CMD_RUN,   16'h0000,0,16'h0000,1,1,0, mk_exp(1,0,0,0,0,0,0));
        add(0,1,CMD_SET_BP,16'hFFFF,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,0,CMD_RUN,   16'h0000,1,16'hFFFF,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,1,CMD_SET_BP,16'h0010,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));
        add(0,1,CMD_HALT,  16'h0000,1,16'h0010,0,0,0, mk_exp(0,1,0,0,1,0,0));
        add(1,0,CMD_RUN,   16'h0000,0,16'h0000,0,0,0, mk_exp(1,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].valid, vecs[i].cmd, vecs[i].arg, vecs[i].fetch,
                           vecs[i].pc, vecs[i].active, vecs[i].stopped, vecs[i].ack);
            tick();
            check_output($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
        end

        // Halt with the decoder reporting stopped five cycles after the request.
        apply_stimulus(0, 1, CMD_HALT, '0, 0, '0, 0, 0, 0);
        tick();
        check_output("halt_stopx", 32'(bus.DEBUG_STOPX), 32'd1);
        apply_stimulus(0, 0, CMD_RUN, '0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check_output("halting_wait", 32'(bus.HALTED), 32'd0);
        apply_stimulus(0, 0, CMD_RUN, '0, 0, '0, 1, 1, 0);
        tick();
        check_output("halted_after_cond", 32'({bus.HALTED, bus.CMD_READY}), 32'b11);

        // Three steps with ACK six cycles after REQ and released one cycle after REQ falls.
        apply_stimulus(0, 1, CMD_STEP, 16'h0003, 0, '0, 1, 1, 0);
        prev_req = 0;
        tick();
        bus.CMD_VALID = 0;
        ack = 0; req_cnt = 0; rel_cnt = 0; rises = 0; dones = 0; done_seen = 0;
        trace.delete();
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (bus.DEBUG_STEP_REQ && !prev_req) rises++;
            prev_req = bus.DEBUG_STEP_REQ;
            if (trace.size() == 0 || trace[$] != bus.STEPS_LEFT) trace.push_back(bus.STEPS_LEFT);
            if (bus.STEP_DONE) begin
                dones++;
                done_seen = 1;
            end
            if (!done_seen) begin
                if (bus.DEBUG_STEP_REQ) begin
                    req_cnt++; rel_cnt = 0;
                    if (req_cnt >= 6) ack = 1;
                end else begin
                    req_cnt = 0;
                    if (ack) begin
                        rel_cnt++;
                        if (rel_cnt >= 2) ack = 0;
                    end
                end
                bus.DEBUG_STEP_ACK = ack;
                tick();
            end
        end
        check_output("step_finished", 32'(done_seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.STEP_DONE) dones++;
            if (bus.DEBUG_STEP_REQ && !prev_req) rises++;
            prev_req = bus.DEBUG_STEP_REQ;
        end
        check_output("step_req_pulses", 32'(rises), 32'd3);
        check_output("step_done_pulses", 32'(dones), 32'd1);
        check_output("step_halted", 32'(bus.HALTED), 32'd1);
        check_output("steps_trace_len", 32'(trace.size()), 32'd4);
        for (int i = 0; i < trace.size() && i < 4; i++)
            check_output($sformatf("steps_trace%0d", i), 32'(trace[i]), 32'(3 - i));

        // Zero-count step: done pulse only, no handshake.
        apply_stimulus(0, 1, CMD_STEP, 16'h0000, 0, '0, 1, 1, 0);
        tick();
        check_output("step0_done", 32'({bus.STEP_DONE, bus.DEBUG_STEP_REQ}), 32'b10);
        bus.CMD_VALID = 0;
        tick();
        check_output("step0_done_clear", 32'(bus.STEP_DONE), 32'd0);

        // Reset in the middle of a step request.
        apply_stimulus(0, 1, CMD_STEP, 16'h0003, 0, '0, 1, 1, 0);
        tick();
        check_output("mid_step_req", 32'(bus.DEBUG_STEP_REQ), 32'd1);
        apply_stimulus(1, 0, CMD_RUN, '0, 0, '0, 1, 1, 0);
        tick();
        check_output("reset_mid_step",
                     32'({bus.DEBUG_STEP_REQ, bus.DEBUG_STOPX, bus.CMD_READY, bus.STEPS_LEFT}),
                     32'({1'b0, 1'b0, 1'b1, 8'd0}));
        RESET = 0;

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            rc = 2'($urandom_range(0, 3));
            RESET              = ($urandom_range(0, 99) == 0);
            bus.CMD_VALID      = $urandom_range(0, 1);
            bus.CMD            = rc;
            if (rc == CMD_SET_BP) begin
                case ($urandom_range(0, 2))
                    0:       bus.CMD_ARG = 16'h0010;
                    1:       bus.CMD_ARG = 16'h0011;
                    default: bus.CMD_ARG = 16'hFFFF;
                endcase
            end else begin
                bus.CMD_ARG = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 3))};
            end
            bus.FETCH          = $urandom_range(0, 1);
            bus.PC             = 16'h0010 + 16'($urandom_range(0, 1));
            bus.DEBUG_ACTIVE   = ($urandom_range(0, 9) < 7);
            bus.STOPPED        = ($urandom_range(0, 9) < 7);
            bus.DEBUG_STEP_ACK = $urandom_range(0, 1);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
